// File: rtl/addsub_arbiter_if.sv
// Two-requester / one-consumer bundle for the nibble-serial add/sub arbiter.
// rsp_ovf is present only when ADDSUB_ARB_OVF_EN is defined.
interface addsub_arbiter_if #(
    parameter int NIB = 4
);
    localparam int W = 4 * NIB;

    logic         req0_valid;
    logic         req0_ready;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_mode;

    logic         req1_valid;
    logic         req1_ready;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_mode;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [W-1:0] rsp_result;
    logic         rsp_carry;
`ifdef ADDSUB_ARB_OVF_EN
    logic         rsp_ovf;
`endif

    logic         busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_mode,
        input  req1_valid, req1_a, req1_b, req1_mode,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_result, rsp_carry,
        input  rsp_ready,
        output busy
`ifdef ADDSUB_ARB_OVF_EN
        , output rsp_ovf
`endif
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_mode,
        output req1_valid, req1_a, req1_b, req1_mode,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry,
        output rsp_ready,
        input  busy
`ifdef ADDSUB_ARB_OVF_EN
        , input rsp_ovf
`endif
    );
endinterface

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter feeding a nibble-serial adder/subtractor; optional rsp_ovf via ADDSUB_ARB_OVF_EN.
// Latency: handshake in cycle T gives rsp_valid in cycle T+NIB+1; one operation in flight.
// Backpressure: result held in DONE until rsp_ready; requesters see ready only in IDLE.
module addsub_arbiter #(
    parameter int NIB = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    addsub_arbiter_if.slave bus
);
    localparam int W = 4 * NIB;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;

    logic         last_grant;
    logic         grant;
    logic         both_vld;
    logic         hs;
    logic         ready0;
    logic         ready1;
    logic         rsp_vld;
    logic         busy_int;

    logic [2:0]   idx;
    logic         last_nib;
    logic         carry;
    logic         mode_r;
    logic         id_r;
    logic [W-1:0] a_r;
    logic [W-1:0] b_r;
    logic [W-1:0] acc;
    logic [W-1:0] acc_nxt;
    logic [3:0]   a_nib;
    logic [3:0]   bx_nib;
    logic [4:0]   nib_sum;

    logic [W-1:0] res_q;
    logic         id_q;
    logic         carry_q;
`ifdef ADDSUB_ARB_OVF_EN
    logic         ovf_q;
    logic         ovf_nib;
`endif

    // With both valid, the requester not served last wins; otherwise the lone one.
    assign both_vld = bus.req0_valid & bus.req1_valid;
    assign grant    = both_vld ? ~last_grant : bus.req1_valid;

    assign last_nib = (idx == 3'(NIB - 1));

    // Operands shift right each CALC cycle, so the working nibble is always [3:0].
    assign a_nib    = a_r[3:0];
    assign bx_nib   = b_r[3:0] ^ {4{mode_r}};
    assign nib_sum  = {1'b0, a_nib} + {1'b0, bx_nib} + {4'd0, carry};
    assign acc_nxt  = (acc >> 4) | (W'(nib_sum[3:0]) << (W - 4));

`ifdef ADDSUB_ARB_OVF_EN
    // Same-sign operands producing an opposite-sign sum == carry-in(MSB) ^ carry-out.
    assign ovf_nib  = (a_nib[3] == bx_nib[3]) & (nib_sum[3] != a_nib[3]);
`endif

    always_comb begin
        state_nxt = state;
        ready0    = 1'b0;
        ready1    = 1'b0;
        rsp_vld   = 1'b0;
        busy_int  = 1'b0;
        case (state)
            IDLE: begin
                ready0 = rst_n & bus.req0_valid & ~grant;
                ready1 = rst_n & bus.req1_valid & grant;
                if (ready0 | ready1) begin
                    state_nxt = CALC;
                end
            end
            CALC: begin
                busy_int = rst_n;
                if (last_nib) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_int = rst_n;
                rsp_vld  = rst_n;
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign hs = ready0 | ready1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
            idx        <= 3'd0;
            carry      <= 1'b0;
            mode_r     <= 1'b0;
            id_r       <= 1'b0;
            a_r        <= '0;
            b_r        <= '0;
            acc        <= '0;
            res_q      <= '0;
            id_q       <= 1'b0;
            carry_q    <= 1'b0;
`ifdef ADDSUB_ARB_OVF_EN
            ovf_q      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (hs) begin
                        a_r        <= grant ? bus.req1_a : bus.req0_a;
                        b_r        <= grant ? bus.req1_b : bus.req0_b;
                        mode_r     <= grant ? bus.req1_mode : bus.req0_mode;
                        carry      <= grant ? bus.req1_mode : bus.req0_mode;
                        id_r       <= grant;
                        idx        <= 3'd0;
                        acc        <= '0;
                        last_grant <= grant;
                    end
                end
                CALC: begin
                    a_r   <= a_r >> 4;
                    b_r   <= b_r >> 4;
                    acc   <= acc_nxt;
                    carry <= nib_sum[4];
                    idx   <= idx + 3'd1;
                    // Response registers move only here, so they hold outside DONE.
                    if (last_nib) begin
                        res_q   <= acc_nxt;
                        carry_q <= nib_sum[4];
                        id_q    <= id_r;
`ifdef ADDSUB_ARB_OVF_EN
                        ovf_q   <= ovf_nib;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.rsp_valid  = rsp_vld;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_result = res_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.busy       = busy_int;
`ifdef ADDSUB_ARB_OVF_EN
    assign bus.rsp_ovf    = ovf_q;
`endif
endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed cases plus random traffic scored against
// an arithmetic reference and a cycle-count model of grant/latency/backpressure.
module tb_addsub_arbiter;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    addsub_arbiter_if #(.NIB(NIB)) bif();

    addsub_arbiter #(.NIB(NIB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (got === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        logic         id;
        logic [W-1:0] res;
        logic         carry;
        logic         ovf;
    } rsp_t;

    // Reference: plain integer arithmetic on the operands.
    function automatic rsp_t ref_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                    input logic mode);
        rsp_t r;
        int ua;
        int ub;
        int sa;
        int sb;
        int exact_u;
        int exact_s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (mode) begin
            exact_u = ua - ub;
            exact_s = sa - sb;
            r.carry = (ua >= ub);
        end else begin
            exact_u = ua + ub;
            exact_s = sa + sb;
            r.carry = (exact_u >= (1 << W));
        end
        r.res = W'(exact_u);
        r.ovf = (exact_s > ((1 << (W - 1)) - 1)) || (exact_s < -(1 << (W - 1)));
        r.id  = id;
        return r;
    endfunction

    rsp_t         exp_q[$];
    int           rsp_cyc_log[$];
    bit           rsp_id_log[$];

    bit           mdl_busy = 1'b0;
    bit           mdl_last = 1'b1;
    int           mdl_due  = 0;
    bit           was_busy;
    bit           exp_v;
    bit           g;
    bit           e0;
    bit           e1;
    logic [W-1:0] hold_res   = '0;
    logic         hold_id    = 1'b0;
    logic         hold_carry = 1'b0;
    logic         hold_ovf   = 1'b0;
    rsp_t         front;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_req0_ready", bif.req0_ready, 0);
            check("rst_req1_ready", bif.req1_ready, 0);
            check("rst_rsp_valid", bif.rsp_valid, 0);
            check("rst_busy", bif.busy, 0);
            mdl_busy   = 1'b0;
            mdl_last   = 1'b1;
            hold_res   = '0;
            hold_id    = 1'b0;
            hold_carry = 1'b0;
            hold_ovf   = 1'b0;
            exp_q.delete();
        end else begin
            was_busy = mdl_busy;
            exp_v    = was_busy && (cyc >= mdl_due);
            check("rsp_valid", bif.rsp_valid, exp_v);
            check("busy", bif.busy, was_busy);
            e0 = 1'b0;
            e1 = 1'b0;
            if (!was_busy) begin
                g  = (bif.req0_valid && bif.req1_valid) ? !mdl_last : bif.req1_valid;
                e0 = bif.req0_valid && !g;
                e1 = bif.req1_valid && g;
            end
            check("req0_ready", bif.req0_ready, e0);
            check("req1_ready", bif.req1_ready, e1);
            if (bif.rsp_valid) begin
                check("rsp_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    front = exp_q[0];
                    check("rsp_id", bif.rsp_id, front.id);
                    check("rsp_result", bif.rsp_result, front.res);
                    check("rsp_carry", bif.rsp_carry, front.carry);
`ifdef ADDSUB_ARB_OVF_EN
                    check("rsp_ovf", bif.rsp_ovf, front.ovf);
`endif
                    if (bif.rsp_ready) begin
                        hold_res   = front.res;
                        hold_id    = front.id;
                        hold_carry = front.carry;
                        hold_ovf   = front.ovf;
                        void'(exp_q.pop_front());
                        rsp_cyc_log.push_back(cyc);
                        rsp_id_log.push_back(front.id);
                        mdl_busy = 1'b0;
                    end
                end
            end else begin
                check("hold_result", bif.rsp_result, hold_res);
                check("hold_id", bif.rsp_id, hold_id);
                check("hold_carry", bif.rsp_carry, hold_carry);
`ifdef ADDSUB_ARB_OVF_EN
                check("hold_ovf", bif.rsp_ovf, hold_ovf);
`endif
            end
            if (!was_busy && bif.req0_valid && bif.req0_ready) begin
                exp_q.push_back(ref_op(1'b0, bif.req0_a, bif.req0_b, bif.req0_mode));
                mdl_busy = 1'b1;
                mdl_due  = cyc + NIB + 1;
                mdl_last = 1'b0;
            end else if (!was_busy && bif.req1_valid && bif.req1_ready) begin
                exp_q.push_back(ref_op(1'b1, bif.req1_a, bif.req1_b, bif.req1_mode));
                mdl_busy = 1'b1;
                mdl_due  = cyc + NIB + 1;
                mdl_last = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit id, input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit mode);
        if (id) begin
            bif.req1_valid = v;
            bif.req1_a     = a;
            bif.req1_b     = b;
            bif.req1_mode  = mode;
        end else begin
            bif.req0_valid = v;
            bif.req0_a     = a;
            bif.req0_b     = b;
            bif.req0_mode  = mode;
        end
    endtask

    task automatic wait_hs(input bit id, output int hs_cyc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (id ? (bif.req1_valid && bif.req1_ready) : (bif.req0_valid && bif.req0_ready)) ok = 1'b1;
        end
        check("handshake_seen", ok, 1);
        hs_cyc = cyc;
    endtask

    task automatic wait_rsp();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 30 && !ok; i++) begin
            @(negedge clk);
            if (bif.rsp_valid) ok = 1'b1;
        end
        check("rsp_seen", ok, 1);
    endtask

    task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b, input bit mode,
                          input logic [W-1:0] er, input bit ec);
        int hs;
        bif.rsp_ready = 1'b1;
        drive(!id, 1'b0, '0, '0, 1'b0);
        drive(id, 1'b1, a, b, mode);
        wait_hs(id, hs);
        step();
        drive(id, 1'b0, a, b, mode);
        wait_rsp();
        check("latency", cyc - hs, NIB + 1);
        check("op_result", bif.rsp_result, er);
        check("op_carry", bif.rsp_carry, ec);
        check("op_id", bif.rsp_id, id);
        step();
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b0, {(W - 1){1'b1}}};
            3: return {1'b1, {(W - 1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog expired (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int hs;
        logic [W-1:0] held;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        bif.rsp_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        step();

        run_op(1'b0, 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0);
        run_op(1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0);
        run_op(1'b1, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
        run_op(1'b0, 16'h8000, 16'h0000, 1'b1, 16'h8000, 1'b1);

        // Continuous contention straight out of reset.
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        rsp_cyc_log.delete();
        rsp_id_log.delete();
        bif.rsp_ready = 1'b1;
        drive(1'b0, 1'b1, 16'h1111, 16'h0101, 1'b0);
        drive(1'b1, 1'b1, 16'h2222, 16'h0202, 1'b1);
        for (int i = 0; i < 60 && rsp_cyc_log.size() < 4; i++) step();
        check("rr_count", rsp_cyc_log.size() >= 4, 1);
        for (int i = 0; i < 4 && i < rsp_cyc_log.size(); i++) begin
            check("rr_order", rsp_id_log[i], i % 2);
            if (i > 0) check("rr_spacing", rsp_cyc_log[i] - rsp_cyc_log[i - 1], 6);
        end
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        repeat (12) step();

        // Backpressure in DONE with both requesters pending.
        bif.rsp_ready = 1'b0;
        drive(1'b0, 1'b1, 16'h00FF, 16'h0001, 1'b0);
        wait_hs(1'b0, hs);
        step();
        drive(1'b1, 1'b1, 16'h4444, 16'h1111, 1'b0);
        wait_rsp();
        held = bif.rsp_result;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_result", bif.rsp_result, 16'h0100);
            check("bp_stable", bif.rsp_result, held);
            check("bp_valid", bif.rsp_valid, 1);
            check("bp_ready0", bif.req0_ready, 0);
            check("bp_ready1", bif.req1_ready, 0);
            check("bp_busy", bif.busy, 1);
        end
        step();
        bif.rsp_ready = 1'b1;
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("bp_release_idle", bif.busy, 0);
        step();

        // Reset pulse in the middle of CALC drops the operation.
        drive(1'b0, 1'b1, 16'hABCD, 16'h1234, 1'b1);
        wait_hs(1'b0, hs);
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < NIB + 3; i++) begin
            @(negedge clk);
            check("abort_no_rsp", bif.rsp_valid, 0);
            check("abort_idle", bif.busy, 0);
        end
        step();
        run_op(1'b1, 16'h0F0F, 16'hF0F0, 1'b0, 16'hFFFF, 1'b0);

`ifdef ADDSUB_ARB_OVF_EN
        run_op(1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
        check("ovf_7fff", bif.rsp_ovf, 1);
`endif

        for (int i = 0; i < 1500; i++) begin
            step();
            drive(1'b0, $urandom_range(0, 2) != 0, pick_operand(), pick_operand(), 1'($urandom));
            drive(1'b1, $urandom_range(0, 2) != 0, pick_operand(), pick_operand(), 1'($urandom));
            bif.rsp_ready = $urandom_range(0, 3) != 0;
        end
        step();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, 1'b0);
        bif.rsp_ready = 1'b1;
        repeat (15) step();
        check("drain_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
REQ-001 SHALL have parameter NIB, default 4: nibbles per operand; operand width W = 4*NIB; legal range 1..8.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester N holds an operation.
REQ-005 SHALL have ports req0_ready / req1_ready  output  1  requester N operation accepted this cycle.
REQ-006 SHALL have ports req0_a, req0_b, req1_a, req1_b  input  W  operands.
REQ-007 SHALL have ports req0_mode / req1_mode  input  1  0 = A+B, 1 = A-B.
REQ-008 SHALL have port rsp_valid  output  1  result available.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-010 SHALL have ports rsp_id  output  1 (requester index), rsp_result  output  W, rsp_carry  output  1 (carry out; for subtract, 1 = no borrow).
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-013 IDLE: reqN_ready SHALL be asserted combinationally only for the granted requester, and only while that requester's valid is high; at most one ready high per cycle.
REQ-014 Grant SHALL be round-robin: with one valid, grant it; with both valid, grant the requester not granted last.
REQ-015 On handshake (valid & ready), the block SHALL latch a, b, mode and id, set carry = mode and nibble index = 0, then enter CALC.
REQ-016 CALC SHALL process one nibble per cycle, LSB first: nib = a[i] + (b[i] XOR {4{mode}}) + carry; store nib into result[i]; carry takes the nibble carry out.
REQ-017 After nibble NIB-1, the block SHALL enter DONE; rsp_carry = final carry.
REQ-018 Latency: handshake in cycle T SHALL give rsp_valid high in cycle T+NIB+1; the block does not pipeline, so at most one operation is in flight.
REQ-019 DONE: rsp_valid SHALL be 1, and rsp_id, rsp_result and rsp_carry SHALL stay stable until rsp_ready is sampled high; then return to IDLE.
REQ-020 A new request SHALL NOT be accepted in the DONE-to-IDLE transfer cycle; the earliest next acceptance is the cycle after.
REQ-021 rsp_valid SHALL be 0 in IDLE and CALC; rsp_result, rsp_id and rsp_carry SHALL hold their last values outside DONE.
REQ-022 Requester inputs SHALL be ignored outside IDLE; a requester dropping valid before handshake is not an error.
REQ-023 Arithmetic SHALL wrap modulo 2^W: 0xFFFF+0x0001 gives 0x0000 with carry 1.

Reset
REQ-024 With rst_n low at a rising edge: state = IDLE, last-grant = 1 (so req0 wins the first contention), nibble index = 0, carry = 0, rsp_result = 0, rsp_id = 0, rsp_carry = 0.
REQ-025 While rst_n is low, req0_ready, req1_ready, rsp_valid and busy SHALL be 0.
REQ-026 Reset asserted in CALC or DONE SHALL abort the operation without emitting a response; the aborted request is lost.

Configuration
REQ-027 Macro ADDSUB_ARB_OVF_EN defined: the block SHALL add output rsp_ovf (1 bit) = signed overflow = carry into MSB XOR final carry, valid and stable with rsp_result, reset value 0.
REQ-028 Macro ADDSUB_ARB_OVF_EN undefined: the rsp_ovf port and its logic SHALL be absent; all other behaviour is identical.

Verification (NIB=4)
REQ-029 req0 0x1234 + 0x0FFF (mode 0), handshake at T -> rsp_valid at T+5; result 0x2233, carry 0, id 0.
REQ-030 req1 0x0005 - 0x0007 (mode 1) -> result 0xFFFE, carry 0, id 1; then 0xFFFF + 0x0001 -> 0x0000, carry 1.
REQ-031 After reset, both valid continuously, rsp_ready tied 1 -> grants in order 0,1,0,1; each response 6 cycles apart from the previous one.
REQ-032 rsp_ready held low 3 cycles in DONE -> rsp_* stable, both readies 0, busy 1; release -> IDLE the next cycle.
REQ-033 rst_n low for 1 cycle mid-CALC -> next cycle IDLE, no rsp_valid pulse; the following request completes normally.
REQ-034 With ADDSUB_ARB_OVF_EN: 0x7FFF + 0x0001 -> result 0x8000, carry 0, rsp_ovf 1.
